mem_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction-fetch stage and the memory stage of the pipelined processor. Data-stage accesses take priority over fetches. Each access is a multi-cycle transaction with one outstanding at a time. Completion is reported to the requester with a one-cycle done pulse, and read data is returned through 16-bit capture registers that hold their value between completions. A watchdog aborts any transaction that the memory never completes.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data stages, data first, with a watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DM, WAIT_IF} state_t;
  state_t      state_q, state_d;
  logic        owner_dm_q, owner_dm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d, dm_done_q, dm_done_d, err_q, err_d;
  logic        in_dm;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign in_dm   = state_q == WAIT_DM;
  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      // a request still held during its own done pulse must not be reissued
      IDLE: if (!if_done_q && !dm_done_q) begin
        if (dm_rd || dm_wr) begin
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wr_d    = dm_wr;
          owner_dm_d  = 1'b1;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (if_req) begin
          mem_addr_d  = if_addr;
          mem_wr_d    = 1'b0;
          owner_dm_d  = 1'b0;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 16'h0000;
        state_d = owner_dm_q ? WAIT_DM : WAIT_IF;
      end
      default: if (mem_done) begin
        if_done_d  = !in_dm;
        dm_done_d  = in_dm;
        if_rdata_d = in_dm ? if_rdata_q : mem_rdata;
        dm_rdata_d = (in_dm && !mem_wr_q) ? mem_rdata : dm_rdata_q;
        state_d    = IDLE;
      end else if (cnt_inc == 17'(TIMEOUT)) begin
        err_d     = 1'b1;
        if_done_d = !in_dm;
        dm_done_d = in_dm;
        state_d   = IDLE;
      end else begin
        cnt_d = cnt_inc[15:0];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      cnt_q       <= 16'h0000;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      dm_rdata_q  <= 16'h0000;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = (dm_rd | dm_wr) & ~dm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of priority, timing, write handling, watchdog and reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_rd = 1'b0, dm_wr = 1'b0, mem_done = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;
  int          tests = 0, fails = 0;
  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_en", 16'(mem_en), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_dm_rdata", dm_rdata, 16'h0000);
    chk("rst_err", 16'(err), 16'd0);
    // fetch read
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    chk("if_mem_en", 16'(mem_en), 16'd1);
    chk("if_mem_addr", mem_addr, 16'h0040);
    chk("if_mem_wr", 16'(mem_wr), 16'd0);
    chk("if_stall_busy", 16'(if_stall), 16'd1);
    tick();
    chk("if_mem_en_once", 16'(mem_en), 16'd0);
    tick();
    mem_done = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    mem_done = 1'b0;
    chk("if_done", 16'(if_done), 16'd1);
    chk("if_rdata", if_rdata, 16'hA5A5);
    chk("if_stall_done", 16'(if_stall), 16'd0);
    if_req = 1'b0; mem_rdata = 16'h0000;
    tick();
    chk("if_done_pulse", 16'(if_done), 16'd0);
    chk("if_rdata_hold", if_rdata, 16'hA5A5);
    chk("if_no_reissue", 16'(mem_en), 16'd0);
    // simultaneous requests: data first
    if_req = 1'b1; if_addr = 16'h0080; dm_rd = 1'b1; dm_addr = 16'h1000;
    tick();
    chk("pri_mem_en", 16'(mem_en), 16'd1);
    chk("pri_mem_addr", mem_addr, 16'h1000);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_done = 1'b0;
    chk("pri_dm_done", 16'(dm_done), 16'd1);
    chk("pri_dm_rdata", dm_rdata, 16'h5A5A);
    chk("pri_dm_stall", 16'(dm_stall), 16'd0);
    chk("pri_if_stall", 16'(if_stall), 16'd1);
    chk("pri_if_done0", 16'(if_done), 16'd0);
    dm_rd = 1'b0;
    tick();
    chk("pri_gap_mem_en", 16'(mem_en), 16'd0);
    chk("pri_gap_if_stall", 16'(if_stall), 16'd1);
    tick();
    chk("pri_if_mem_en", 16'(mem_en), 16'd1);
    chk("pri_if_mem_addr", mem_addr, 16'h0080);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_done = 1'b0;
    chk("pri_if_done", 16'(if_done), 16'd1);
    chk("pri_if_rdata", if_rdata, 16'h1111);
    chk("pri_dm_rdata_keep", dm_rdata, 16'h5A5A);
    if_req = 1'b0;
    tick();
    // data write
    dm_wr = 1'b1; dm_addr = 16'h2002; dm_wdata = 16'hBEEF;
    tick();
    chk("wr_mem_en", 16'(mem_en), 16'd1);
    chk("wr_mem_wr", 16'(mem_wr), 16'd1);
    chk("wr_mem_addr", mem_addr, 16'h2002);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    dm_addr = 16'h0000; dm_wdata = 16'h0000;
    tick();
    tick();
    chk("wr_wdata_hold", mem_wdata, 16'hBEEF);
    chk("wr_addr_hold", mem_addr, 16'h2002);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0;
    chk("wr_dm_done", 16'(dm_done), 16'd1);
    chk("wr_dm_rdata_keep", dm_rdata, 16'h5A5A);
    chk("wr_err", 16'(err), 16'd0);
    dm_wr = 1'b0;
    tick();
    // watchdog abort with silent memory
    dm_rd = 1'b1; dm_addr = 16'h3000;
    tick();
    chk("to_mem_en", 16'(mem_en), 16'd1);
    tick(); tick(); tick(); tick();
    chk("to_err_early", 16'(err), 16'd0);
    chk("to_done_early", 16'(dm_done), 16'd0);
    tick();
    chk("to_err", 16'(err), 16'd1);
    chk("to_dm_done", 16'(dm_done), 16'd1);
    chk("to_dm_rdata_keep", dm_rdata, 16'h5A5A);
    dm_rd = 1'b0;
    tick();
    chk("to_err_pulse", 16'(err), 16'd0);
    // next request after abort; completion lands in the timeout cycle
    dm_rd = 1'b1; dm_addr = 16'h3004;
    tick();
    chk("to_next_mem_en", 16'(mem_en), 16'd1);
    chk("to_next_addr", mem_addr, 16'h3004);
    tick(); tick(); tick(); tick();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_done = 1'b0;
    chk("race_dm_done", 16'(dm_done), 16'd1);
    chk("race_err", 16'(err), 16'd0);
    chk("race_dm_rdata", dm_rdata, 16'h7777);
    dm_rd = 1'b0;
    tick();
    // reset while waiting, then a stray completion
    dm_rd = 1'b1; dm_addr = 16'h4000;
    tick();
    chk("rw_mem_en", 16'(mem_en), 16'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_rd = 1'b0;
    chk("rw_mem_addr", mem_addr, 16'h0000);
    chk("rw_dm_rdata", dm_rdata, 16'h0000);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h9999;
    tick();
    mem_done = 1'b0;
    chk("rw_dm_done", 16'(dm_done), 16'd0);
    chk("rw_err", 16'(err), 16'd0);
    chk("rw_dm_rdata_after", dm_rdata, 16'h0000);
    chk("rw_mem_en_after", 16'(mem_en), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
